// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with duty control and tick strobe

module clk_div_prog #(
  parameter int CNT_W        = 17,
  parameter int DIV_DEFAULT  = 50000,
  parameter int HIGH_DEFAULT = 25000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ZERO      = '0;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] HIGH_INIT = CNT_W'(HIGH_DEFAULT);

  // Period counter and registered outputs
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // Active configuration governing the current period
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;

  // Shadow configuration waiting for a period boundary
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic [CNT_W-1:0] phigh_q, phigh_d;
  logic             pend_q, pend_d;

  // Combinational helpers
  logic [CNT_W-1:0] div_clamp;
  logic [CNT_W-1:0] high_floor;
  logic [CNT_W-1:0] high_clamp;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             cfg_accept;
  logic             wrap;
  logic             apply;

  // The slot is free whenever nothing is waiting to be applied
  assign cfg_ready  = ~pend_q;
  assign cfg_accept = cfg_valid & ~pend_q;

  // Clamp requested values so the period has at least one low and one high cycle
  always_comb begin
    div_clamp  = (cfg_div < TWO) ? TWO : cfg_div;
    high_floor = (cfg_high < ONE) ? ONE : cfg_high;
    high_clamp = (high_floor > (div_clamp - ONE)) ? (div_clamp - ONE) : high_floor;
  end

  // Period boundary detection and apply condition
  always_comb begin
    last_cnt = div_q - ONE;
    low_cnt  = div_q - high_q;
    wrap     = en & (cnt_q == last_cnt);
    // A disabled divider has no period in flight, so a pending config can land at once
    apply    = pend_q & (wrap | ~en);
  end

  // Counter and output next-state
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = tick_q;
    if (en) begin
      cnt_d     = wrap ? ZERO : (cnt_q + ONE);
      // On wrap cnt_d is 0 and low_cnt is at least 1, so the new period always opens low
      // regardless of whether fresh values are applied on this edge.
      clk_out_d = (cnt_d >= low_cnt);
      tick_d    = wrap;
    end else begin
      cnt_d     = ZERO;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end
  end

  // Configuration next-state: shadow load on accept, transfer to active on apply
  always_comb begin
    div_d   = div_q;
    high_d  = high_q;
    pdiv_d  = pdiv_q;
    phigh_d = phigh_q;
    pend_d  = pend_q;
    if (apply) begin
      div_d  = pdiv_q;
      high_d = phigh_q;
      pend_d = 1'b0;
    end
    // Accept needs pend_q low and apply needs it high, so the two never collide
    if (cfg_accept) begin
      pdiv_d  = div_clamp;
      phigh_d = high_clamp;
      pend_d  = 1'b1;
    end
  end

  // Counter, outputs and active configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= ZERO;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      div_q     <= DIV_INIT;
      high_q    <= HIGH_INIT;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
      high_q    <= high_d;
    end
  end

  // Shadow configuration registers; reset drops any half-finished handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pdiv_q  <= DIV_INIT;
      phigh_q <= HIGH_INIT;
      pend_q  <= 1'b0;
    end else begin
      pdiv_q  <= pdiv_d;
      phigh_q <= phigh_d;
      pend_q  <= pend_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule
